// File: rtl/miter_pkg.sv
// Shared definitions for the miter mismatch tracker: default widths,
// FSM state encoding and a sizing helper for the warm-up timer.
package miter_pkg;

    localparam int WIDTH_DEF  = 91;
    localparam int WARMUP_DEF = 4;
    localparam int CYC_W_DEF  = 32;
    localparam int MCNT_W_DEF = 16;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_CHECK  = 2'd1,
        ST_FAIL   = 2'd2
    } state_t;

    // Width of the warm-up down-counter; it only needs to hold WARMUP-1.
    function automatic int wu_width(input int warmup);
        return (warmup > 1) ? $clog2(warmup) : 1;
    endfunction

endpackage

// File: rtl/miter_mismatch_tracker_sat_counter.sv
// Saturating up-counter with enable and synchronous active-low clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         en,
    output logic [W-1:0] count
);

    // Count enabled events, stop at the maximum value.
    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (en && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/miter_mismatch_tracker.sv
// Mismatch tracker downstream of the equivalence miter. Skips a warm-up
// window of valid cycles, then latches the first divergence between y_1
// and y_2 and keeps saturating checked/mismatch counts.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_WARMUP | settling window, valid samples counted but not compared
// ST_CHECK  | comparing every valid sample, no divergence seen yet
// ST_FAIL   | first divergence captured; terminal until reset
module miter_mismatch_tracker
    import miter_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int WARMUP = WARMUP_DEF,
    parameter int CYC_W  = CYC_W_DEF,
    parameter int MCNT_W = MCNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [WIDTH-1:0]  y_1,
    input  logic [WIDTH-1:0]  y_2,
    output logic              checking,
    output logic              fail,
    output logic [CYC_W-1:0]  first_cycle,
    output logic [WIDTH-1:0]  first_diff,
    output logic [MCNT_W-1:0] mismatch_cnt,
    output logic [CYC_W-1:0]  checked_cnt
);

    localparam int             WU_W    = wu_width(WARMUP);
    // Down-counter loaded with WARMUP-1; the valid that arrives while it
    // reads zero is the last warm-up sample.
    localparam logic [WU_W-1:0] WU_LOAD = (WARMUP > 1) ? WU_W'(WARMUP - 1) : '0;
    localparam state_t         RST_ST  = (WARMUP == 0) ? ST_CHECK : ST_WARMUP;

    state_t            state;
    state_t            state_nxt;
    logic [WU_W-1:0]   wu_cnt;
    logic [CYC_W-1:0]  vidx;
    logic              mism;
    logic              chk_en;
    logic              mis_en;
    logic              cap_en;

    assign mism = (y_1 != y_2);

    // State register and warm-up down-counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= RST_ST;
            wu_cnt <= WU_LOAD;
        end else begin
            state <= state_nxt;
            if (in_valid && (state == ST_WARMUP) && (wu_cnt != '0)) begin
                wu_cnt <= wu_cnt - WU_W'(1);
            end
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_WARMUP: if (in_valid && (wu_cnt == '0)) state_nxt = ST_CHECK;
            ST_CHECK:  if (in_valid && mism)           state_nxt = ST_FAIL;
            ST_FAIL:   state_nxt = ST_FAIL;
            default:   state_nxt = RST_ST;
        endcase
    end

    // Output decode and counter/capture enables.
    always_comb begin
        checking = 1'b0;
        fail     = 1'b0;
        chk_en   = 1'b0;
        mis_en   = 1'b0;
        cap_en   = 1'b0;
        case (state)
            ST_CHECK: begin
                checking = 1'b1;
                chk_en   = in_valid;
                mis_en   = in_valid && mism;
                cap_en   = in_valid && mism;
            end
            ST_FAIL: begin
                checking = 1'b1;
                fail     = 1'b1;
                chk_en   = in_valid;
                mis_en   = in_valid && mism;
            end
            default: ;
        endcase
    end

    // First-divergence capture; written only on the CHECK->FAIL transition.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first_cycle <= '0;
            first_diff  <= '0;
        end else if (cap_en) begin
            first_cycle <= vidx;
            first_diff  <= y_1 ^ y_2;
        end
    end

    sat_counter #(.W(CYC_W)) u_vidx (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (in_valid),
        .count (vidx)
    );

    sat_counter #(.W(CYC_W)) u_checked (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (chk_en),
        .count (checked_cnt)
    );

    sat_counter #(.W(MCNT_W)) u_mismatch (
        .clk   (clk),
        .clr_n (rst_n),
        .en    (mis_en),
        .count (mismatch_cnt)
    );

endmodule

// File: tb/tb_miter_mismatch_tracker.sv
// Scoreboard bench for miter_mismatch_tracker. Two instances share the
// stimulus: A uses the default configuration, B has no warm-up, an 8-bit
// cycle index and a 2-bit mismatch counter so saturation is reachable.
module tb_miter_mismatch_tracker;

    localparam int W = 91;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] y_1 = '0;
    logic [W-1:0] y_2 = '0;

    logic         a_checking, a_fail;
    logic [31:0]  a_first_cycle, a_checked_cnt;
    logic [W-1:0] a_first_diff;
    logic [15:0]  a_mismatch_cnt;

    logic         b_checking, b_fail;
    logic [7:0]   b_first_cycle, b_checked_cnt;
    logic [W-1:0] b_first_diff;
    logic [1:0]   b_mismatch_cnt;

    miter_mismatch_tracker #(.WIDTH(W), .WARMUP(4), .CYC_W(32), .MCNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .y_1(y_1), .y_2(y_2),
        .checking(a_checking), .fail(a_fail), .first_cycle(a_first_cycle),
        .first_diff(a_first_diff), .mismatch_cnt(a_mismatch_cnt), .checked_cnt(a_checked_cnt)
    );

    miter_mismatch_tracker #(.WIDTH(W), .WARMUP(0), .CYC_W(8), .MCNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .y_1(y_1), .y_2(y_2),
        .checking(b_checking), .fail(b_fail), .first_cycle(b_first_cycle),
        .first_diff(b_first_diff), .mismatch_cnt(b_mismatch_cnt), .checked_cnt(b_checked_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a history summary (valids seen, first divergence,
    // unbounded counts); saturation applied only when forming expectations.
    typedef struct {
        longint       n;
        bit           failed;
        longint       fcyc;
        logic [W-1:0] fdiff;
        longint       mc;
        longint       cc;
    } mdl_t;

    typedef struct {
        logic         checking;
        logic         fail;
        longint       first_cycle;
        logic [W-1:0] first_diff;
        longint       mcnt;
        longint       ccnt;
    } exp_t;

    mdl_t ma, mb;
    exp_t qa[$];
    exp_t qb[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   done = 0;

    function automatic longint lmax(input int bits);
        return (longint'(1) << bits) - 1;
    endfunction

    function automatic longint lmin(input longint x, input longint y);
        return (x < y) ? x : y;
    endfunction

    function automatic mdl_t mdl_step(input mdl_t m, input bit r, input bit v,
                                      input logic [W-1:0] a, input logic [W-1:0] b,
                                      input int warmup, input int cyc_w);
        mdl_t o;
        o = m;
        if (!r) begin
            o.n = 0; o.failed = 0; o.fcyc = 0; o.fdiff = '0; o.mc = 0; o.cc = 0;
        end else if (v) begin
            if (m.n >= warmup) begin
                o.cc = m.cc + 1;
                if (a != b) begin
                    o.mc = m.mc + 1;
                    if (!m.failed) begin
                        o.failed = 1;
                        o.fcyc   = lmin(m.n, lmax(cyc_w));
                        o.fdiff  = a ^ b;
                    end
                end
            end
            o.n = m.n + 1;
        end
        return o;
    endfunction

    function automatic exp_t mdl_out(input mdl_t m, input int warmup, input int cyc_w, input int mcnt_w);
        exp_t e;
        e.checking    = (m.n >= warmup);
        e.fail        = m.failed;
        e.first_cycle = m.fcyc;
        e.first_diff  = m.fdiff;
        e.mcnt        = lmin(m.mc, lmax(mcnt_w));
        e.ccnt        = lmin(m.cc, lmax(cyc_w));
        return e;
    endfunction

    function automatic logic [W-1:0] rnd();
        logic [95:0] t;
        t = {$urandom, $urandom, $urandom};
        return t[W-1:0];
    endfunction

    function automatic logic [W-1:0] rnd_nz();
        logic [W-1:0] d;
        logic [W-1:0] one;
        one = W'(1);
        if ($urandom_range(1) == 0) d = one << $urandom_range(W - 1);
        else                        d = rnd();
        if (d == '0) d = one;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Drive one cycle at the falling edge and queue what the outputs must
    // read after the following rising edge.
    task automatic cyc(input bit r, input bit v, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        y_1      = a;
        y_2      = b;
        ma = mdl_step(ma, r, v, a, b, 4, 32);
        mb = mdl_step(mb, r, v, a, b, 0, 8);
        qa.push_back(mdl_out(ma, 4, 32, 16));
        qb.push_back(mdl_out(mb, 0, 8, 2));
    endtask

    // Monitor: after each rising edge, pop and compare one expectation.
    initial begin
        exp_t ea, eb;
        forever begin
            @(posedge clk);
            #1;
            if (qa.size() > 0 && qb.size() > 0) begin
                ea = qa.pop_front();
                eb = qb.pop_front();
                chk("a_checking",     a_checking,     ea.checking);
                chk("a_fail",         a_fail,         ea.fail);
                chk("a_first_cycle",  a_first_cycle,  ea.first_cycle);
                chk("a_first_diff",   a_first_diff,   ea.first_diff);
                chk("a_mismatch_cnt", a_mismatch_cnt, ea.mcnt);
                chk("a_checked_cnt",  a_checked_cnt,  ea.ccnt);
                chk("b_checking",     b_checking,     eb.checking);
                chk("b_fail",         b_fail,         eb.fail);
                chk("b_first_cycle",  b_first_cycle,  eb.first_cycle);
                chk("b_first_diff",   b_first_diff,   eb.first_diff);
                chk("b_mismatch_cnt", b_mismatch_cnt, eb.mcnt);
                chk("b_checked_cnt",  b_checked_cnt,  eb.ccnt);
            end
        end
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] one_v, three_v;
        one_v   = W'(1);
        three_v = W'(3);
        ma = mdl_step(ma, 0, 0, '0, '0, 4, 32);
        mb = mdl_step(mb, 0, 0, '0, '0, 0, 8);

        // Reset hold; the last reset cycle also carries a mismatching valid.
        cyc(0, 0, '0, '0);
        cyc(0, 0, '0, '0);
        a = rnd(); cyc(0, 1, a, a ^ rnd_nz());

        // 20 valids: differing during warm-up, directed mismatches at 9/12/15.
        for (int i = 0; i < 20; i++) begin
            a = rnd();
            if (i < 4)                 cyc(1, 1, a, a ^ rnd_nz());
            else if (i == 9)           cyc(1, 1, one_v, three_v);
            else if (i == 12 || i == 15) cyc(1, 1, a, a ^ rnd_nz());
            else                       cyc(1, 1, a, a);
        end

        // Idle with differing inputs: nothing may move.
        for (int i = 0; i < 5; i++) begin
            a = rnd(); cyc(1, 0, a, a ^ rnd_nz());
        end

        // Mid-run reset together with a mismatching valid, then restart.
        a = rnd(); cyc(0, 1, a, a ^ rnd_nz());

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 400; i++) begin
            bit r, v;
            r = ($urandom_range(99) != 0);
            v = ($urandom_range(9) < 8);
            a = rnd();
            if ($urandom_range(9) == 0) cyc(r, v, a, a ^ rnd_nz());
            else                        cyc(r, v, a, a);
        end

        // Long clean run so B's 8-bit cycle index saturates before the
        // first divergence.
        cyc(0, 0, '0, '0);
        for (int i = 0; i < 300; i++) begin
            a = rnd(); cyc(1, 1, a, a);
        end
        for (int i = 0; i < 4; i++) begin
            a = rnd(); cyc(1, 1, a, a ^ rnd_nz());
        end
        cyc(1, 0, '0, '0);

        repeat (2) @(posedge clk);
        #2;
        chk("queue_drain", 128'(qa.size() + qb.size()), 128'd0);
        done = 1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        if (!done) begin
            $display("FAIL timeout: got running expected finished");
            $fatal(1, "timeout");
        end
    end

endmodule
